// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, fetch fault codes, the bubble
// instruction and the opcode constants used by the hazard unit.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    KILL,
    DONE
  } fetch_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_ACCESS   = 2'b01,
    FAULT_MISALIGN = 2'b10
  } fault_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/fetch_unit_if.sv
// Wishbone-style instruction fetch port (read-only, single outstanding cycle).
interface fetch_unit_if;
  logic [31:0] addr;
  logic        cyc;
  logic        stb;
  logic [31:0] dat;
  logic        ack;
  logic        err;

  modport master (output addr, cyc, stb, input dat, ack, err);
  modport slave  (input addr, cyc, stb, output dat, ack, err);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: clear beats enable; enable without a valid fetch
// loads a bubble.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [31:0] BUBBLE = core_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  fault_e      fault_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output fault_e      fault_o
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o    <= '0;
      instr_o <= BUBBLE;
      fault_o <= FAULT_NONE;
    end else if (clear_i) begin
      pc_o    <= '0;
      instr_o <= BUBBLE;
      fault_o <= FAULT_NONE;
    end else if (en_i && valid_i) begin
      pc_o    <= pc_i;
      instr_o <= instr_i;
      fault_o <= fault_i;
    end else if (en_i) begin
      pc_o    <= '0;
      instr_o <= BUBBLE;
      fault_o <= FAULT_NONE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, runs one instruction fetch at a time over the
// Wishbone port, and feeds the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pc_en_i,
  input  logic                en_ifid_i,
  input  logic                clear_ifid_i,
  input  logic                trap_i,
  input  logic [31:0]         trap_vector_i,
  input  logic                mret_i,
  input  logic [31:0]         mepc_i,
  input  logic                branch_taken_i,
  input  logic [31:0]         branch_target_i,
  fetch_unit_if.master        iwbm,
  output logic                is_IF_o,
  output logic [31:0]         pc_id_o,
  output logic [31:0]         instr_id_o,
  output logic [1:0]          fault_id_o
);
  import core_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, addr_q, addr_d, ibuf_q, ibuf_d, next_pc;
  fault_e       fault_q, fault_d, fault_id;
  logic         redirect;

  assign redirect = trap_i | mret_i | branch_taken_i;

  always_comb begin
    if (trap_i)              next_pc = trap_vector_i;
    else if (mret_i)         next_pc = mepc_i;
    else if (branch_taken_i) next_pc = branch_target_i;
    else                     next_pc = pc_q + 32'd4;
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ibuf_d  = ibuf_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (pc_en_i && redirect) begin
          pc_d    = next_pc;
          state_d = KILL;
        end else if (iwbm.ack) begin
          ibuf_d  = iwbm.dat;
          fault_d = FAULT_NONE;
          state_d = DONE;
        end else if (iwbm.err) begin
          ibuf_d  = NOP_INSTR;
          fault_d = FAULT_ACCESS;
          state_d = DONE;
        end
      end
      KILL: begin
        // The stale cycle must complete before the corrected fetch starts.
        if (pc_en_i && redirect) pc_d = next_pc;
        if (iwbm.ack || iwbm.err) begin
          addr_d = pc_d;
          if (pc_d[1:0] != 2'b00) begin
            ibuf_d  = NOP_INSTR;
            fault_d = FAULT_MISALIGN;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      DONE: begin
        if (pc_en_i) begin
          pc_d   = next_pc;
          addr_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            ibuf_d  = NOP_INSTR;
            fault_d = FAULT_MISALIGN;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDR;
      addr_q  <= RESET_ADDR;
      ibuf_q  <= NOP_INSTR;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ibuf_q  <= ibuf_d;
      fault_q <= fault_d;
    end
  end

  assign iwbm.addr = addr_q;
  assign iwbm.cyc  = (state_q == REQ) || (state_q == KILL);
  assign iwbm.stb  = iwbm.cyc;
  assign is_IF_o   = (state_q != DONE);

  if_id_reg #(.BUBBLE(NOP_INSTR)) u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_ifid_i),
    .en_i    (en_ifid_i),
    .valid_i (state_q == DONE),
    .pc_i    (pc_q),
    .instr_i (ibuf_q),
    .fault_i (fault_q),
    .pc_o    (pc_id_o),
    .instr_o (instr_id_o),
    .fault_o (fault_id)
  );

  assign fault_id_o = fault_id;

  // Advancing the PC while IF/ID neither captures nor flushes would lose an instruction.
  illegal_pc_en_in_done: assert property (@(posedge clk_i) disable iff (rst_i)
    !(state_q == DONE && pc_en_i && !en_ifid_i && !clear_ifid_i));

endmodule
